// File: rtl/multi_dataflow_stream_merge.sv
// N-channel stream merger: per-channel FIFOs arbitrated onto one tagged output with per-job beat counting.
// Define MULTI_DATAFLOW_MERGE_ERR_EN to build the sticky excess-beat / illegal-start detector on err_o.

// Per-channel FIFO with registered storage and a combinational head read.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: full_o blocks a push unless a pop happens in the same cycle.
module multi_dataflow_merge_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & (~full_o | pop_i);
  assign w_pop   = pop_i & ~empty_o;
  assign dat_o   = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clr_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end
endmodule

// Merges N_IN buffered input streams onto one output register tagged with the source channel.
// Latency: 2 cycles from input handshake to out_valid_o (FIFO write, then arbiter pop into the output register).
// Backpressure: out_ready_i low holds the output register; FIFOs fill and in_ready_o drops per channel.
module multi_dataflow_stream_merge #(
  parameter int N_IN       = 3,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [CNT_WIDTH-1:0]       len_i,
  input  logic                       mode_i,
  input  logic [N_IN-1:0]            in_valid_i,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data_i,
  output logic [N_IN-1:0]            in_ready_o,
  output logic                       out_valid_o,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic [$clog2(N_IN)-1:0]    out_src_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);
  localparam int SW = $clog2(N_IN);
  localparam int OW = CNT_WIDTH + SW;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic                  r_mode;
  logic [CNT_WIDTH-1:0]  r_in_cnt [N_IN];
  logic [OW-1:0]         r_out_cnt;
  logic [SW-1:0]         r_last_grant;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_dat;
  logic [SW-1:0]         r_out_src;

  logic [N_IN-1:0]       w_full;
  logic [N_IN-1:0]       w_empty;
  logic [N_IN-1:0]       w_in_hs;
  logic [N_IN-1:0]       w_pop;
  logic [DATA_WIDTH-1:0] w_fifo_dat [N_IN];
  logic [SW-1:0]         w_grant;
  logic [SW:0]           w_idx;
  logic                  w_any;
  logic                  w_run;
  logic                  w_start;
  logic                  w_load;
  logic                  w_out_hs;
  logic                  w_done;
  logic [OW-1:0]         w_out_cnt_inc;
  logic [OW-1:0]         w_total;

  assign w_run         = (r_state == S_RUN);
  assign w_start       = (r_state == S_IDLE) & start_i;
  assign w_out_hs      = r_out_vld & out_ready_i;
  assign w_out_cnt_inc = r_out_cnt + OW'(1);
  assign w_total       = OW'(r_len) * OW'(N_IN);
  assign w_load        = w_run & (~r_out_vld | out_ready_i) & w_any;

  genvar g;
  generate
    for (g = 0; g < N_IN; g++) begin : g_ch
      assign in_ready_o[g] = w_run & ~w_full[g] & (r_in_cnt[g] < r_len);
      assign w_in_hs[g]    = in_ready_o[g] & in_valid_i[g];
      assign w_pop[g]      = w_load & (w_grant == SW'(g));

      multi_dataflow_merge_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clear_i),
        .push_i  (w_in_hs[g]),
        .dat_i   (in_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
        .pop_i   (w_pop[g]),
        .dat_o   (w_fifo_dat[g]),
        .full_o  (w_full[g]),
        .empty_o (w_empty[g])
      );
    end
  endgenerate

  // Both searches walk from lowest to highest priority so the last hit wins.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    if (r_mode) begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (!w_empty[i]) begin
          w_grant = SW'(i);
          w_any   = 1'b1;
        end
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        w_idx = {1'b0, r_last_grant} + (SW+1)'(1) + (SW+1)'(i);
        if (w_idx >= (SW+1)'(N_IN)) w_idx = w_idx - (SW+1)'(N_IN);
        if (!w_empty[w_idx[SW-1:0]]) begin
          w_grant = w_idx[SW-1:0];
          w_any   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_RUN;
      S_RUN: begin
        if ((r_len == '0) || (w_out_hs && (w_out_cnt_inc == w_total))) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear_i) begin
      w_state_nxt = S_IDLE;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len        <= '0;
      r_mode       <= 1'b0;
      r_out_cnt    <= '0;
      r_last_grant <= SW'(N_IN - 1);
      r_out_vld    <= 1'b0;
      r_out_dat    <= '0;
      r_out_src    <= '0;
      for (int k = 0; k < N_IN; k++) r_in_cnt[k] <= '0;
    end else if (clear_i) begin
      r_out_cnt    <= '0;
      r_last_grant <= SW'(N_IN - 1);
      r_out_vld    <= 1'b0;
      for (int k = 0; k < N_IN; k++) r_in_cnt[k] <= '0;
    end else if (w_start) begin
      r_len     <= len_i;
      r_mode    <= mode_i;
      r_out_cnt <= '0;
      for (int k = 0; k < N_IN; k++) r_in_cnt[k] <= '0;
    end else begin
      if (w_out_hs) r_out_cnt <= w_out_cnt_inc;
      for (int k = 0; k < N_IN; k++) begin
        if (w_in_hs[k]) r_in_cnt[k] <= r_in_cnt[k] + CNT_WIDTH'(1);
      end
      if (w_load) begin
        r_out_vld    <= 1'b1;
        r_out_dat    <= w_fifo_dat[w_grant];
        r_out_src    <= w_grant;
        r_last_grant <= w_grant;
      end else if (out_ready_i) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_out_vld;
  assign out_data_o  = r_out_dat;
  assign out_src_o   = r_out_src;
  assign busy_o      = w_run;
  assign done_o      = w_done;

`ifdef MULTI_DATAFLOW_MERGE_ERR_EN
  logic r_err;
  logic w_err_set;

  always_comb begin
    w_err_set = w_run & start_i;
    for (int k = 0; k < N_IN; k++) begin
      if (w_run && in_valid_i[k] && (r_in_cnt[k] == r_len)) w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= r_err | w_err_set;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_multi_dataflow_stream_merge.sv
// Directed bench for multi_dataflow_stream_merge with a per-channel-ordered scoreboard.
module tb_multi_dataflow_stream_merge;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int CW = 16;
`ifdef MULTI_DATAFLOW_MERGE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] len = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [N*DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          busy, done, err;

  int n_chk = 0;
  int n_err = 0;
  int job = 0;
  int seq [N];
  int cyc = 0;
  int n_out, n_done, done_at, cyc_first_in, cyc_first_ov;
  logic [DW-1:0] sb [$];
  int exp_src [$];
  logic s_busy, s_done, s_ov;
  logic [DW-1:0] s_dat;
  logic [N-1:0] s_rdy, rdy_seen;

  multi_dataflow_stream_merge #(.N_IN(N), .DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .len_i(len), .mode_i(mode),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_src_o(out_src), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int j, input int c, input int s);
    return {j[7:0], c[7:0], s[15:0]};
  endfunction

  always_comb begin
    for (int k = 0; k < N; k++) in_data[k*DW +: DW] = mk(job, k, seq[k]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_sb();
    int idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i][23:16] == 8'(out_src)) idx = i;
    end
    chk("sb_entry", 64'(idx >= 0), 1);
    if (idx >= 0) begin
      chk("out_data", out_data, sb[idx]);
      sb.delete(idx);
    end
  endtask

  // Samples at the falling edge, then advances past the next rising edge.
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    cyc++;
    hs = in_valid & in_ready;
    s_busy = busy; s_done = done; s_ov = out_valid; s_dat = out_data; s_rdy = in_ready;
    rdy_seen = rdy_seen | in_ready;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        sb.push_back(in_data[k*DW +: DW]);
        if (cyc_first_in < 0) cyc_first_in = cyc;
      end
    end
    if (out_valid && cyc_first_ov < 0) cyc_first_ov = cyc;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_src.size() > 0) chk("out_src", 64'(out_src), 64'(exp_src.pop_front()));
      pop_sb();
    end
    if (done) begin
      n_done++;
      done_at = n_out;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (hs[k]) seq[k]++;
  endtask

  task automatic new_job(input int l, input logic m, input logic [N-1:0] v, input logic r);
    job++;
    n_out = 0; n_done = 0; done_at = -1; cyc_first_in = -1; cyc_first_ov = -1;
    rdy_seen = '0;
    for (int k = 0; k < N; k++) seq[k] = 0;
    len = CW'(l); mode = m; in_valid = v; out_ready = r; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int i = 0;
    while (n_done == 0 && i < budget) begin
      step();
      i++;
    end
    chk("done_within_budget", 64'(n_done), 1);
  endtask

  initial begin
    for (int k = 0; k < N; k++) seq[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();

    // Round-robin, len=4, free-flowing.
    for (int i = 0; i < 12; i++) exp_src.push_back(i % 3);
    new_job(4, 1'b0, 3'b111, 1'b1);
    run_until_done(40);
    chk("rr_beats", 64'(n_out), 12);
    chk("rr_done_at", 64'(done_at), 12);
    chk("rr_latency", 64'(cyc_first_ov - cyc_first_in), 2);
    chk("rr_sb_empty", 64'(sb.size()), 0);
    step();
    chk("rr_idle_busy", s_busy, 0);
    chk("rr_single_done", 64'(n_done), 1);

    // Fixed priority with pre-filled FIFOs.
    new_job(2, 1'b1, 3'b111, 1'b0);
    repeat (5) step();
    for (int i = 0; i < 6; i++) exp_src.push_back(i / 2);
    out_ready = 1'b1;
    run_until_done(30);
    chk("fp_beats", 64'(n_out), 6);
    chk("fp_done_at", 64'(done_at), 6);
    chk("fp_src_all_seen", 64'(exp_src.size()), 0);

    // Long stall: FIFOs fill, output holds.
    new_job(8, 1'b0, 3'b111, 1'b0);
    repeat (20) begin
      step();
      if (s_ov) chk("stall_data", s_dat, mk(job, 0, 0));
    end
    chk("stall_in_ready", s_rdy, 0);
    chk("stall_out_valid", s_ov, 1);
    out_ready = 1'b1;
    run_until_done(60);
    chk("stall_beats", 64'(n_out), 24);
    chk("stall_done_at", 64'(done_at), 24);
    chk("stall_sb_empty", 64'(sb.size()), 0);

    // len = 0.
    new_job(0, 1'b0, 3'b111, 1'b1);
    step();
    chk("len0_busy", s_busy, 1);
    chk("len0_done", s_done, 1);
    step();
    chk("len0_busy_after", s_busy, 0);
    chk("len0_done_after", s_done, 0);
    chk("len0_no_ready", rdy_seen, 0);

    // Clear mid-job with 5 beats buffered.
    new_job(4, 1'b0, 3'b111, 1'b0);
    step();
    in_valid = 3'b011;
    step();
    in_valid = 3'b000;
    step();
    chk("clr_buffered", 64'(sb.size()), 5);
    chk("clr_out_loaded", s_ov, 1);
    clear = 1'b1;
    step();
    chk("clr_no_done", s_done, 0);
    clear = 1'b0;
    step();
    chk("clr_out_valid", s_ov, 0);
    chk("clr_busy", s_busy, 0);
    chk("clr_done_count", 64'(n_done), 0);
    sb.delete();
    new_job(1, 1'b0, 3'b111, 1'b1);
    run_until_done(20);
    chk("clr_new_beats", 64'(n_out), 3);
    chk("clr_new_sb_empty", 64'(sb.size()), 0);

    // Excess beats and sticky err_o.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_after_rst", err, 0);
    new_job(2, 1'b0, 3'b111, 1'b1);
    run_until_done(20);
    step();
    chk("err_after_done", err, ERR_EXP);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    chk("err_after_clear", err, ERR_EXP);

    // Asynchronous reset mid-job.
    new_job(4, 1'b0, 3'b111, 1'b1);
    step();
    step();
    chk("arst_busy_before", s_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_err", err, 0);
    chk("arst_done", done, 0);
    step();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
